controladora_multizona: RTL

CONTROLADORA_MULTIZONA -- requirements
Module: controladora_multizona

---
 rtl/iluminacao_pkg.sv | 24 ++
 rtl/zona_iluminacao.sv | 118 +++++++++++
 rtl/controladora_multizona.sv | 38 +++
 3 files changed

// File: rtl/iluminacao_pkg.sv
// Shared types for the multi-zone lighting controller: button/lamp FSM states
// and the counter-width helper used by every zone.
package iluminacao_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        DEBOUNCE,
        CURTO,
        LONGO
    } botao_estado_t;

    typedef enum logic [1:0] {
        DESL_AUTO,
        LIG_AUTO,
        LIG_MAN,
        DESL_MAN
    } lampada_estado_t;

    // One counter width serves both the press timer and the idle timer.
    function automatic int largura_contador(input int t_modo, input int t_desligar);
        return $clog2(((t_modo > t_desligar) ? t_modo : t_desligar) + 1);
    endfunction

endpackage

// File: rtl/zona_iluminacao.sv
// One lighting zone: input synchronizers, press classifier and lamp FSM.
// Optional macro CONTROLADORA_AVISO_EN enables the pre-shutdown warning output.
module zona_iluminacao
    import iluminacao_pkg::*;
#(
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000,
    parameter int WARN_T            = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_infravermelho,
    input  logic i_push_button,
    input  logic i_desligar_todos,
    output logic o_led,
    output logic o_saida,
    output logic o_aviso
);

    localparam int CW = largura_contador(SWITCH_MODE_MIN_T, AUTO_SHUTDOWN_T);
    localparam logic [CW-1:0] UM        = CW'(1);
    localparam logic [CW-1:0] DEB_FIM   = CW'(DEBOUNCE_P - 1);
    localparam logic [CW-1:0] LONGO_FIM = CW'(SWITCH_MODE_MIN_T - 1);
    localparam logic [CW-1:0] BOTAO_MAX = CW'(SWITCH_MODE_MIN_T);
    localparam logic [CW-1:0] OCIO_FIM  = CW'(AUTO_SHUTDOWN_T - 1);
    localparam logic [CW-1:0] OCIO_MAX  = CW'(AUTO_SHUTDOWN_T);

    logic [1:0]      r_ir_sync, r_pb_sync;
    botao_estado_t   r_botao_estado, w_botao_prox;
    lampada_estado_t r_lamp_estado, w_lamp_prox;
    logic [CW-1:0]   r_botao_cnt, w_botao_cnt_prox;
    logic [CW-1:0]   r_ocio_cnt, w_ocio_cnt_prox;
    logic            w_presenca, w_botao;
    logic            w_pulso_curto, w_pulso_longo, w_timeout;

    assign w_presenca = r_ir_sync[1];
    assign w_botao    = r_pb_sync[1];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir_sync      <= '0;
            r_pb_sync      <= '0;
            r_botao_estado <= OCIOSO;
            r_botao_cnt    <= '0;
            r_lamp_estado  <= DESL_AUTO;
            r_ocio_cnt     <= '0;
        end else begin
            r_ir_sync      <= {r_ir_sync[0], i_infravermelho};
            r_pb_sync      <= {r_pb_sync[0], i_push_button};
            r_botao_estado <= w_botao_prox;
            r_botao_cnt    <= w_botao_cnt_prox;
            r_lamp_estado  <= w_lamp_prox;
            r_ocio_cnt     <= w_ocio_cnt_prox;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_botao_prox = r_botao_estado;
        case (r_botao_estado)
            OCIOSO:   if (w_botao) w_botao_prox = DEBOUNCE;
            DEBOUNCE: if (!w_botao) w_botao_prox = OCIOSO;
                      else if (r_botao_cnt >= DEB_FIM) w_botao_prox = CURTO;
            CURTO:    if (!w_botao) w_botao_prox = OCIOSO;
                      else if (r_botao_cnt >= LONGO_FIM) w_botao_prox = LONGO;
            LONGO:    if (!w_botao) w_botao_prox = OCIOSO;
            default:  w_botao_prox = OCIOSO;
        endcase

        // Press timer runs across DEBOUNCE and CURTO and saturates in LONGO.
        w_botao_cnt_prox = '0;
        if (w_botao && (r_botao_estado != OCIOSO))
            w_botao_cnt_prox = (r_botao_cnt < BOTAO_MAX) ? r_botao_cnt + UM : r_botao_cnt;
    end

    always_comb begin
        w_pulso_curto = (r_botao_estado == CURTO) && !w_botao;
        w_pulso_longo = (r_botao_estado == LONGO) && !w_botao;
    end

    assign w_timeout = (r_lamp_estado == LIG_AUTO) && !w_presenca && (r_ocio_cnt >= OCIO_FIM);

    always_comb begin
        w_lamp_prox = r_lamp_estado;
        if (i_desligar_todos)
            w_lamp_prox = DESL_AUTO;
        else if (w_pulso_longo)
            w_lamp_prox = (r_lamp_estado inside {DESL_AUTO, LIG_AUTO}) ? DESL_MAN : LIG_AUTO;
        else if (w_timeout)
            w_lamp_prox = DESL_AUTO;
        else if (w_pulso_curto && (r_lamp_estado inside {LIG_MAN, DESL_MAN}))
            w_lamp_prox = (r_lamp_estado == LIG_MAN) ? DESL_MAN : LIG_MAN;
        else if (w_presenca && (r_lamp_estado == DESL_AUTO))
            w_lamp_prox = LIG_AUTO;

        // Idle timer only survives while staying in LIG_AUTO without presence.
        w_ocio_cnt_prox = '0;
        if ((r_lamp_estado == LIG_AUTO) && (w_lamp_prox == LIG_AUTO) && !w_presenca)
            w_ocio_cnt_prox = (r_ocio_cnt < OCIO_MAX) ? r_ocio_cnt + UM : r_ocio_cnt;
    end

`ifdef CONTROLADORA_AVISO_EN
    localparam logic [CW-1:0] AVISO_INI = CW'(AUTO_SHUTDOWN_T - WARN_T);
`endif

    always_comb begin
        o_led   = r_lamp_estado inside {LIG_MAN, DESL_MAN};
        o_saida = r_lamp_estado inside {LIG_AUTO, LIG_MAN};
`ifdef CONTROLADORA_AVISO_EN
        o_aviso = (r_lamp_estado == LIG_AUTO) && (r_ocio_cnt >= AVISO_INI);
`else
        o_aviso = 1'b0;
`endif
    end

endmodule

// File: rtl/controladora_multizona.sv
// Multi-zone lighting controller top: N_ZONAS independent zones sharing desligar_todos.
// Optional macro CONTROLADORA_AVISO_EN enables the per-zone warning output.
module controladora_multizona #(
    parameter int N_ZONAS           = 4,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000,
    parameter int WARN_T            = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONAS-1:0] infravermelho,
    input  logic [N_ZONAS-1:0] push_button,
    input  logic               desligar_todos,
    output logic [N_ZONAS-1:0] led,
    output logic [N_ZONAS-1:0] saida,
    output logic [N_ZONAS-1:0] aviso
);

    for (genvar g = 0; g < N_ZONAS; g++) begin : g_zona
        zona_iluminacao #(
            .DEBOUNCE_P       (DEBOUNCE_P),
            .SWITCH_MODE_MIN_T(SWITCH_MODE_MIN_T),
            .AUTO_SHUTDOWN_T  (AUTO_SHUTDOWN_T),
            .WARN_T           (WARN_T)
        ) u_zona (
            .clk             (clk),
            .rst             (rst),
            .i_infravermelho (infravermelho[g]),
            .i_push_button   (push_button[g]),
            .i_desligar_todos(desligar_todos),
            .o_led           (led[g]),
            .o_saida         (saida[g]),
            .o_aviso         (aviso[g])
        );
    end

endmodule
